// File: rtl/trans_latency_sequencer_pkg.sv
// rtl/trans_latency_sequencer_pkg.sv - shared types and constants for the latency sequencer
package tls_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    IDLE,
    WARMUP,
    MEASURE,
    HOLD,
    DONE
  } state_t;

  // Latency register width; MAX_MEAS must fit in it
  localparam int LAT_W = 8;

  // Default L1 drive levels: strong current settles near phase 1, weak near phase 40
  localparam logic [7:0] CUR_A_DEF = 8'd200;
  localparam logic [7:0] CUR_B_DEF = 8'd5;

  // Even segments/transitions drive cur_a, odd ones cur_b
  function automatic logic [7:0] pick_cur(input logic odd, input logic [7:0] cur_a,
                                          input logic [7:0] cur_b);
    return odd ? cur_b : cur_a;
  endfunction

endpackage

// File: rtl/trans_latency_sequencer_if.sv
// rtl/trans_latency_sequencer_if.sv - control, sample and result bundle of the latency sequencer
interface trans_latency_sequencer_if #(
  parameter int N_TRANS = 6
);
  import tls_pkg::*;

  logic                   cycle_start;
  logic                   start;
  logic                   abort;
  logic [7:0]             err_a;
  logic [7:0]             err_b;
  logic [7:0]             cur_out;
  logic                   busy;
  logic                   done;
  logic [2:0]             trans_idx;
  logic [2:0]             rd_idx;
  logic [LAT_W-1:0]       rd_lat_a;
  logic [LAT_W-1:0]       rd_lat_b;
  logic [N_TRANS-1:0]     a_faster;
  logic                   verdict;

  modport slave (
    input  cycle_start, start, abort, err_a, err_b, rd_idx,
    output cur_out, busy, done, trans_idx, rd_lat_a, rd_lat_b, a_faster, verdict
  );

  modport master (
    output cycle_start, start, abort, err_a, err_b, rd_idx,
    input  cur_out, busy, done, trans_idx, rd_lat_a, rd_lat_b, a_faster, verdict
  );

endinterface

// File: rtl/trans_latency_sequencer_latency_capture.sv
// rtl/trans_latency_sequencer_latency_capture.sv - per-channel hit flag and latency register array
module latency_capture
  import tls_pkg::*;
#(
  parameter int N_TRANS  = 6,
  parameter int MAX_MEAS = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LAT_W-1:0] i_m,
  input  logic [7:0]       i_err,
  input  logic [7:0]       i_thr,
  input  logic             i_sample_en,
  input  logic             i_clear,
  input  logic             i_finalize,
  input  logic [2:0]       i_idx,
  output logic [LAT_W-1:0] o_lat [N_TRANS]
);

  localparam logic [LAT_W-1:0] LAT_MAX = LAT_W'(MAX_MEAS);

  logic             r_hit;
  logic [LAT_W-1:0] r_lat [N_TRANS];
  logic             w_hit;

  // The first sample after a transition edge is never accepted, so a stale low error cannot count
  assign w_hit = i_sample_en && !r_hit && (i_m >= LAT_W'(2)) && (i_err <= i_thr);

  // Record the first converged sample; at the window end unhit channels read as MAX_MEAS
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hit <= 1'b0;
      for (int k = 0; k < N_TRANS; k++) r_lat[k] <= '0;
    end else if (i_clear) begin
      r_hit <= 1'b0;
      for (int k = 0; k < N_TRANS; k++) r_lat[k] <= '0;
    end else begin
      if (w_hit) begin
        r_lat[i_idx] <= i_m;
        r_hit        <= 1'b1;
      end
      if (i_finalize) begin
        r_hit <= 1'b0;
        if (!r_hit && !w_hit) r_lat[i_idx] <= LAT_MAX;
      end
    end
  end

  assign o_lat = r_lat;

endmodule

// File: rtl/trans_latency_sequencer.sv
// rtl/trans_latency_sequencer.sv - warm-up/transition stimulus scheduler and convergence-latency meter
module trans_latency_sequencer
  import tls_pkg::*;
#(
  parameter int         N_TRANS    = 6,
  parameter int         WARMUP_SEG = 4,
  parameter int         HOLD_CYC   = 30,
  parameter int         MAX_MEAS   = 12,
  parameter int         ERR_THR    = 3,
  parameter logic [7:0] CUR_A      = CUR_A_DEF,
  parameter logic [7:0] CUR_B      = CUR_B_DEF
) (
  input logic                      clk,
  input logic                      rst,
  trans_latency_sequencer_if.slave bus
);

  localparam int                GC_W     = $clog2(HOLD_CYC + 1);
  localparam int                SEG_W    = $clog2(WARMUP_SEG + 1);
  localparam logic [GC_W-1:0]   GC_LAST  = GC_W'(HOLD_CYC - 1);
  localparam logic [SEG_W-1:0]  SEG_LAST = SEG_W'(WARMUP_SEG - 1);
  localparam logic [LAT_W-1:0]  M_LAST   = LAT_W'(MAX_MEAS - 1);
  localparam logic [2:0]        T_LAST   = 3'(N_TRANS - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [GC_W-1:0]  r_gcnt;
  logic [SEG_W-1:0] r_seg;
  logic [LAT_W-1:0] r_m;
  logic [2:0]       r_tidx;
  logic [7:0]       r_cur;

  logic             w_busy;
  logic             w_done;
  logic             w_launch;
  logic             w_abort;
  logic             w_pulse;
  logic             w_gc_wrap;
  logic             w_warm_end;
  logic             w_sample;
  logic             w_meas_last;
  logic             w_hold_end;
  logic [LAT_W-1:0] w_m_nxt;
  logic [LAT_W-1:0] w_lat_a [N_TRANS];
  logic [LAT_W-1:0] w_lat_b [N_TRANS];
  logic [LAT_W-1:0] w_rd_a;
  logic [LAT_W-1:0] w_rd_b;
  logic [N_TRANS-1:0] w_a_faster;

  // abort beats start in IDLE/DONE and beats any coincident gamma pulse while busy
  assign w_launch    = ((r_state == IDLE) || (r_state == DONE)) && bus.start && !bus.abort;
  assign w_abort     = w_busy && bus.abort;
  assign w_pulse     = bus.cycle_start && !bus.abort;
  assign w_gc_wrap   = w_pulse && (r_gcnt == GC_LAST);
  assign w_warm_end  = (r_state == WARMUP) && w_gc_wrap && (r_seg == SEG_LAST);
  assign w_sample    = (r_state == MEASURE) && w_pulse;
  assign w_meas_last = w_sample && (r_m == M_LAST);
  assign w_hold_end  = (r_state == HOLD) && w_gc_wrap;
  assign w_m_nxt     = r_m + LAT_W'(1);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state selection
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, DONE: if (w_launch) w_state_nxt = WARMUP;
      WARMUP: begin
        if (bus.abort)      w_state_nxt = IDLE;
        else if (w_warm_end) w_state_nxt = MEASURE;
      end
      MEASURE: begin
        if (bus.abort)        w_state_nxt = IDLE;
        else if (w_meas_last) w_state_nxt = (r_tidx == T_LAST) ? DONE : HOLD;
      end
      HOLD: begin
        if (bus.abort)       w_state_nxt = IDLE;
        else if (w_hold_end) w_state_nxt = MEASURE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Status outputs decoded from the state
  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      WARMUP, MEASURE, HOLD: w_busy = 1'b1;
      DONE:                  w_done = 1'b1;
      default: ;
    endcase
  end

  // Gamma-cycle counters and the L1 drive current; counters only move on non-aborted pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gcnt <= '0;
      r_seg  <= '0;
      r_m    <= '0;
      r_tidx <= '0;
      r_cur  <= '0;
    end else if (w_abort) begin
      r_cur <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (w_launch) begin
            r_cur  <= CUR_A;
            r_gcnt <= '0;
            r_seg  <= '0;
            r_m    <= '0;
            r_tidx <= '0;
          end
        end
        WARMUP: begin
          if (w_gc_wrap) begin
            r_gcnt <= '0;
            if (r_seg == SEG_LAST) begin
              r_cur  <= CUR_A;
              r_tidx <= '0;
              r_m    <= '0;
            end else begin
              r_seg <= r_seg + SEG_W'(1);
              r_cur <= pick_cur(!r_seg[0], CUR_A, CUR_B);
            end
          end else if (w_pulse) begin
            r_gcnt <= r_gcnt + GC_W'(1);
          end
        end
        MEASURE: begin
          if (w_pulse) r_m <= w_m_nxt;
        end
        HOLD: begin
          if (w_gc_wrap) begin
            r_gcnt <= '0;
            r_tidx <= r_tidx + 3'd1;
            r_cur  <= pick_cur(!r_tidx[0], CUR_A, CUR_B);
            r_m    <= '0;
          end else if (w_pulse) begin
            r_gcnt <= r_gcnt + GC_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  latency_capture #(
    .N_TRANS  (N_TRANS),
    .MAX_MEAS (MAX_MEAS)
  ) u_cap_a (
    .clk         (clk),
    .rst         (rst),
    .i_m         (w_m_nxt),
    .i_err       (bus.err_a),
    .i_thr       (8'(ERR_THR)),
    .i_sample_en (w_sample),
    .i_clear     (w_launch),
    .i_finalize  (w_meas_last),
    .i_idx       (r_tidx),
    .o_lat       (w_lat_a)
  );

  latency_capture #(
    .N_TRANS  (N_TRANS),
    .MAX_MEAS (MAX_MEAS)
  ) u_cap_b (
    .clk         (clk),
    .rst         (rst),
    .i_m         (w_m_nxt),
    .i_err       (bus.err_b),
    .i_thr       (8'(ERR_THR)),
    .i_sample_en (w_sample),
    .i_clear     (w_launch),
    .i_finalize  (w_meas_last),
    .i_idx       (r_tidx),
    .o_lat       (w_lat_b)
  );

  // Result read port; indices past the last transition read zero
  always_comb begin
    w_rd_a = '0;
    w_rd_b = '0;
    for (int k = 0; k < N_TRANS; k++) begin
      if (bus.rd_idx == 3'(k)) begin
        w_rd_a = w_lat_a[k];
        w_rd_b = w_lat_b[k];
      end
    end
  end

  // Per-transition speedup flags, compared straight from the latency registers
  always_comb begin
    w_a_faster = '0;
    for (int k = 0; k < N_TRANS; k++) w_a_faster[k] = (w_lat_a[k] < w_lat_b[k]);
  end

  assign bus.cur_out   = r_cur;
  assign bus.busy      = w_busy;
  assign bus.done      = w_done;
  assign bus.trans_idx = r_tidx;
  assign bus.rd_lat_a  = w_rd_a;
  assign bus.rd_lat_b  = w_rd_b;
  assign bus.a_faster  = w_a_faster;
  assign bus.verdict   = w_a_faster[2] & w_a_faster[3];

endmodule

// File: tb/tb_trans_latency_sequencer.sv
// tb/tb_trans_latency_sequencer.sv - scoreboard bench for the latency sequencer
module tb_trans_latency_sequencer;
  import tls_pkg::*;

  localparam int N_TRANS    = 6;
  localparam int WARMUP_SEG = 4;
  localparam int HOLD_CYC   = 30;
  localparam int MAX_MEAS   = 12;
  localparam int RUN_PULSES = 342;

  typedef struct {
    logic [7:0]         la;
    logic [7:0]         lb;
    logic [N_TRANS-1:0] af;
    logic               vd;
    int                 pulses;
  } done_exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  trans_latency_sequencer_if #(.N_TRANS(N_TRANS)) u_if ();

  trans_latency_sequencer #(
    .N_TRANS    (N_TRANS),
    .WARMUP_SEG (WARMUP_SEG),
    .HOLD_CYC   (HOLD_CYC),
    .MAX_MEAS   (MAX_MEAS),
    .ERR_THR    (3),
    .CUR_A      (8'd200),
    .CUR_B      (8'd5)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  int         n_vec = 0;
  int         n_bad = 0;
  int         n_pulse = 0;
  logic [7:0] exp_cur_q [$];
  done_exp_t  exp_done_q [$];
  logic [7:0] prev_cur = 8'd0;
  logic       prev_done = 1'b0;
  logic       mon_own = 1'b0;
  logic [2:0] mon_rd = 3'd0;
  logic [2:0] stim_rd = 3'd0;

  assign u_if.rd_idx = mon_own ? mon_rd : stim_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int m_of(input int n);
    int q;
    if (n <= WARMUP_SEG * HOLD_CYC) return 0;
    q = (n - WARMUP_SEG * HOLD_CYC - 1) % (MAX_MEAS + HOLD_CYC);
    return (q < MAX_MEAS) ? q + 1 : 0;
  endfunction

  // Monitor: pops expected drive levels on each cur_out change and run results on done rising
  always @(negedge clk) begin : mon
    done_exp_t  e;
    logic [7:0] cur_s;
    logic       done_s;
    cur_s  = u_if.cur_out;
    done_s = u_if.done;
    prev_cur  <= cur_s;
    prev_done <= done_s;
    if (cur_s !== prev_cur) begin
      if (exp_cur_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL cur_out_seq: got %0d, expected no change", cur_s);
      end else begin
        chk("cur_out_seq", 32'(cur_s), 32'(exp_cur_q.pop_front()));
      end
    end
    if (done_s === 1'b1 && prev_done !== 1'b1) begin
      if (exp_done_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL done_unexpected: got done=1, expected 0");
      end else begin
        e = exp_done_q.pop_front();
        chk("done_pulse_count", 32'(n_pulse), 32'(e.pulses));
        chk("a_faster", 32'(u_if.a_faster), 32'(e.af));
        chk("verdict", 32'(u_if.verdict), 32'(e.vd));
        mon_own = 1'b1;
        for (int k = 0; k < N_TRANS; k++) begin
          mon_rd = 3'(k);
          #1;
          chk($sformatf("lat_a[%0d]", k), 32'(u_if.rd_lat_a), 32'(e.la));
          chk($sformatf("lat_b[%0d]", k), 32'(u_if.rd_lat_b), 32'(e.lb));
        end
        mon_own = 1'b0;
      end
    end
  end

  task automatic pulse(input int mode, input bit with_start);
    int m;
    @(negedge clk);
    n_pulse++;
    m = m_of(n_pulse);
    case (mode)
      0: begin
        u_if.err_a = (m >= 2) ? 8'd2 : 8'd50;
        u_if.err_b = (m >= 5) ? 8'd1 : 8'd10;
      end
      1: begin
        u_if.err_a = 8'd50;
        u_if.err_b = 8'd50;
      end
      default: begin
        u_if.err_a = 8'd0;
        u_if.err_b = (m >= 4) ? 8'd3 : 8'd4;
      end
    endcase
    u_if.cycle_start = 1'b1;
    u_if.start       = with_start;
    @(negedge clk);
    u_if.cycle_start = 1'b0;
    u_if.start       = 1'b0;
    @(negedge clk);
  endtask

  task automatic launch(input bit with_pulse);
    @(negedge clk);
    n_pulse          = 0;
    u_if.start       = 1'b1;
    u_if.cycle_start = with_pulse;
    @(negedge clk);
    u_if.start       = 1'b0;
    u_if.cycle_start = 1'b0;
  endtask

  task automatic push_run_curs();
    for (int s = 0; s < WARMUP_SEG; s++) exp_cur_q.push_back((s % 2 == 0) ? 8'd200 : 8'd5);
    for (int t = 0; t < N_TRANS; t++) exp_cur_q.push_back((t % 2 == 0) ? 8'd200 : 8'd5);
  endtask

  task automatic push_done(input logic [7:0] la, input logic [7:0] lb,
                           input logic [N_TRANS-1:0] af, input logic vd);
    done_exp_t e;
    e.la = la;
    e.lb = lb;
    e.af = af;
    e.vd = vd;
    e.pulses = RUN_PULSES;
    exp_done_q.push_back(e);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20 && u_if.done !== 1'b1; i++) @(negedge clk);
    chk("done_level", 32'(u_if.done), 32'd1);
    chk("busy_in_done", 32'(u_if.busy), 32'd0);
    chk("done_results_seen", 32'(exp_done_q.size()), 32'd0);
    exp_done_q.delete();
  endtask

  task automatic rd_check(input int idx, input int ea, input int eb);
    stim_rd = 3'(idx);
    #1;
    chk($sformatf("rd_lat_a[%0d]", idx), 32'(u_if.rd_lat_a), 32'(ea));
    chk($sformatf("rd_lat_b[%0d]", idx), 32'(u_if.rd_lat_b), 32'(eb));
  endtask

  initial begin
    rst              = 1'b1;
    u_if.start       = 1'b0;
    u_if.abort       = 1'b0;
    u_if.cycle_start = 1'b0;
    u_if.err_a       = 8'd0;
    u_if.err_b       = 8'd0;
    repeat (2) @(negedge clk);
    chk("rst_cur_out", 32'(u_if.cur_out), 32'd0);
    chk("rst_busy", 32'(u_if.busy), 32'd0);
    chk("rst_done", 32'(u_if.done), 32'd0);
    chk("rst_verdict", 32'(u_if.verdict), 32'd0);
    chk("rst_a_faster", 32'(u_if.a_faster), 32'd0);
    for (int k = 0; k < 8; k++) rd_check(k, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    // Full run: A converges at m=2, B at m=5; a start pulse during a hold is ignored
    push_run_curs();
    push_done(8'd2, 8'd5, 6'b111111, 1'b1);
    launch(1'b0);
    chk("launch_busy", 32'(u_if.busy), 32'd1);
    for (int i = 1; i <= RUN_PULSES; i++) pulse(0, i == 137);
    wait_done();

    // Start coincident with a pulse, then no convergence on either channel
    push_run_curs();
    push_done(8'd12, 8'd12, 6'b000000, 1'b0);
    launch(1'b1);
    for (int i = 1; i <= RUN_PULSES; i++) begin
      pulse(1, 1'b0);
      if (i == HOLD_CYC - 1) chk("seg0_not_ended", 32'(u_if.cur_out), 32'd200);
      if (i == HOLD_CYC)     chk("seg0_ended", 32'(u_if.cur_out), 32'd5);
    end
    wait_done();

    // Abort during the measurement window of transition 3, with a coincident pulse
    for (int s = 0; s < WARMUP_SEG; s++) exp_cur_q.push_back((s % 2 == 0) ? 8'd200 : 8'd5);
    for (int t = 0; t < 4; t++) exp_cur_q.push_back((t % 2 == 0) ? 8'd200 : 8'd5);
    exp_cur_q.push_back(8'd0);
    launch(1'b0);
    for (int i = 1; i <= 249; i++) pulse(0, 1'b0);
    chk("abort_pre_trans_idx", 32'(u_if.trans_idx), 32'd3);
    chk("abort_pre_busy", 32'(u_if.busy), 32'd1);
    @(negedge clk);
    u_if.abort       = 1'b1;
    u_if.cycle_start = 1'b1;
    u_if.err_a       = 8'd0;
    u_if.err_b       = 8'd1;
    @(negedge clk);
    u_if.abort       = 1'b0;
    u_if.cycle_start = 1'b0;
    chk("abort_busy", 32'(u_if.busy), 32'd0);
    chk("abort_done", 32'(u_if.done), 32'd0);
    chk("abort_cur_out", 32'(u_if.cur_out), 32'd0);
    for (int k = 0; k < 3; k++) rd_check(k, 2, 5);
    rd_check(3, 2, 0);
    rd_check(4, 0, 0);
    rd_check(5, 0, 0);

    // abort together with start in IDLE keeps the sequencer idle
    @(negedge clk);
    u_if.abort = 1'b1;
    u_if.start = 1'b1;
    @(negedge clk);
    u_if.abort = 1'b0;
    u_if.start = 1'b0;
    chk("abort_start_busy", 32'(u_if.busy), 32'd0);
    chk("abort_start_cur", 32'(u_if.cur_out), 32'd0);

    // Restart clears results; early-hit guard run: A hits at m=2, B at m=4
    push_run_curs();
    push_done(8'd2, 8'd4, 6'b111111, 1'b1);
    launch(1'b0);
    chk("restart_cur_out", 32'(u_if.cur_out), 32'd200);
    chk("restart_busy", 32'(u_if.busy), 32'd1);
    for (int k = 0; k < N_TRANS; k++) rd_check(k, 0, 0);
    for (int i = 1; i <= RUN_PULSES; i++) pulse(2, 1'b0);
    wait_done();

    // Asynchronous reset between clock edges
    exp_cur_q.push_back(8'd0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_cur_out", 32'(u_if.cur_out), 32'd0);
    chk("arst_busy", 32'(u_if.busy), 32'd0);
    chk("arst_done", 32'(u_if.done), 32'd0);
    chk("arst_verdict", 32'(u_if.verdict), 32'd0);
    chk("arst_a_faster", 32'(u_if.a_faster), 32'd0);
    chk("arst_trans_idx", 32'(u_if.trans_idx), 32'd0);
    for (int k = 0; k < 8; k++) rd_check(k, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", 32'(u_if.busy), 32'd0);
    chk("cur_seq_drained", 32'(exp_cur_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
